// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
// Contents: controller state enum, pipeline NOP encoding, zero-register index.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;
  localparam logic [31:0] NOP      = 32'h0000_0020;
  localparam logic [4:0]  REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and stall/flush outputs of the hazard controller
// slave: controller side (hazard info in, stall/flush/mem_timeout out)
// master: pipeline side (drives hazard info, receives stall/flush/mem_timeout)
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_wraddr;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       ex_mem_stall;
  logic       ex_mem_flush;
  logic       mem_wb_flush;
  logic       mem_timeout;
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wraddr, ex_redirect, mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
           mem_wb_flush, mem_timeout
  );
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wraddr, ex_redirect, mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
           mem_wb_flush, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect_lu.sv
// hazard_detect_lu: combinational load-use comparator between the EX load and the ID sources
// Inputs: ID rs/rt fields and use flags, EX load flag and destination. Output: lu_o.
module hazard_detect_lu
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_wraddr_i,
  output logic       lu_o
);
  assign lu_o = ex_memread_i & (ex_wraddr_i != REG_ZERO) &
                ((id_uses_rs_i & (id_rs_i == ex_wraddr_i)) | (id_uses_rt_i & (id_rt_i == ex_wraddr_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (memory wait, redirect, load-use, timeout)
// Ports: clk, rst (sync active-high), bus (pipe_hazard_ctrl_if.slave).
// Optional: PIPE_HAZARD_PERF_EN adds perf_stall_cycles / perf_flush_events saturating counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flush_events
`endif
);
  state_t           state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;
  logic             lu, memhold, hold, redir, luh;
  hazard_detect_lu u_lu (
    .id_rs_i      (bus.id_rs),
    .id_rt_i      (bus.id_rt),
    .id_uses_rs_i (bus.id_uses_rs),
    .id_uses_rt_i (bus.id_uses_rt),
    .ex_memread_i (bus.ex_memread),
    .ex_wraddr_i  (bus.ex_wraddr),
    .lu_o         (lu)
  );
  assign memhold = bus.mem_req & ~bus.mem_ready;
  // Once waiting, only mem_ready releases the freeze, so redirect/lu stay masked until then.
  assign hold  = ~rst & ((state_q == HALT) | ((state_q == MEM_WAIT) & ~bus.mem_ready) |
                         ((state_q == RUN) & memhold));
  assign redir = ~rst & ~hold & bus.ex_redirect;
  // Redirect wins: the dependent instruction in ID is on the wrong path.
  assign luh   = ~rst & ~hold & ~bus.ex_redirect & lu;
  assign bus.pc_stall     = hold | luh;
  assign bus.if_id_stall  = hold | luh;
  assign bus.if_id_flush  = rst | redir;
  assign bus.id_ex_stall  = hold;
  assign bus.id_ex_flush  = rst | redir | luh;
  assign bus.ex_mem_stall = hold;
  assign bus.ex_mem_flush = rst;
  assign bus.mem_wb_flush = rst | hold;
  assign bus.mem_timeout  = timeout_q & ~rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (memhold) begin
          state_q    <= MEM_WAIT;
          wait_cnt_q <= CNT_W'(1);
        end
        MEM_WAIT: if (bus.mem_ready) begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          state_q   <= HALT;
          timeout_q <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        default: state_q <= HALT;
      endcase
    end
  end
`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      if (bus.pc_stall && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if ((bus.if_id_flush || bus.id_ex_flush) && !(&perf_flush_events))
        perf_flush_events <= perf_flush_events + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: self-checking bench for pipe_hazard_ctrl with a cycle-level reference model
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;
  localparam int TO = 4;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if bus ();
`ifdef PIPE_HAZARD_PERF_EN
  logic [CW-1:0] perf_stall_cycles, perf_flush_events;
`endif
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_events (perf_flush_events)
`endif
  );
  // Model: count of consecutive stalled cycles of the current access, halt/timeout flags, perf tallies.
  int m_stalled = 0;
  bit m_halt = 0;
  bit m_to = 0;
  int m_pst = 0;
  int m_pfl = 0;
  // Output order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //               ex_mem_stall, ex_mem_flush, mem_wb_flush, mem_timeout
  function automatic logic [8:0] outs();
    return {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall, bus.id_ex_flush,
            bus.ex_mem_stall, bus.ex_mem_flush, bus.mem_wb_flush, bus.mem_timeout};
  endfunction
  function automatic bit m_stalling();
    if (m_halt) return 1'b1;
    if (m_stalled > 0) return !bus.mem_ready;
    return bus.mem_req && !bus.mem_ready;
  endfunction
  function automatic logic [8:0] model_out();
    bit lu;
    lu = bus.ex_memread && (bus.ex_wraddr != 5'd0) &&
         ((bus.id_uses_rs && bus.id_rs == bus.ex_wraddr) || (bus.id_uses_rt && bus.id_rt == bus.ex_wraddr));
    if (rst) return 9'b001010110;
    if (m_stalling()) return {8'b11010101, m_to};
    if (bus.ex_redirect) return 9'b001010000;
    if (lu) return 9'b110010000;
    return 9'b000000000;
  endfunction
  function automatic void model_step();
    logic [8:0] e;
    e = model_out();
    if (rst) begin
      m_stalled = 0;
      m_halt = 0;
      m_to = 0;
      m_pst = 0;
      m_pfl = 0;
      return;
    end
    if (e[8] && m_pst < (1 << CW) - 1) m_pst++;
    if ((e[6] || e[4]) && m_pfl < (1 << CW) - 1) m_pfl++;
    if (m_halt) return;
    if (m_stalling()) begin
      m_stalled++;
      if (m_stalled == TO + 1) begin
        m_halt = 1;
        m_to = 1;
      end
    end else m_stalled = 0;
  endfunction
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.ex_memread = 0; bus.ex_wraddr = 0; bus.ex_redirect = 0; bus.mem_req = 0; bus.mem_ready = 1;
  endtask
  task automatic test_reset();
    idle();
    bus.mem_req = 1; bus.mem_ready = 0; bus.ex_redirect = 1;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 9'b001010110) begin
        errors++;
        $display("FAIL reset_outputs: got %b expected %b", outs(), 9'b001010110);
      end
      tick();
    end
    rst = 0;
    idle();
  endtask
  task automatic test_load_use();
    idle();
    bus.ex_memread = 1; bus.ex_wraddr = 8; bus.id_rs = 8; bus.id_uses_rs = 1;
    @(negedge clk);
    checks++;
    if (outs() !== 9'b110010000 || model_out() !== 9'b110010000) begin
      errors++;
      $display("FAIL load_use_bubble: got %b expected %b", outs(), 9'b110010000);
    end
    tick();
    bus.ex_memread = 0;
    @(negedge clk);
    checks++;
    if (outs() !== 9'b0) begin
      errors++;
      $display("FAIL load_use_after: got %b expected %b", outs(), 9'b0);
    end
    tick();
  endtask
  task automatic test_load_zero();
    idle();
    bus.ex_memread = 1; bus.ex_wraddr = 0; bus.id_rs = 0; bus.id_uses_rs = 1; bus.id_uses_rt = 1;
    @(negedge clk);
    checks++;
    if (outs() !== 9'b0) begin
      errors++;
      $display("FAIL load_zero_reg: got %b expected %b", outs(), 9'b0);
    end
    tick();
    idle();
  endtask
  task automatic test_mem_wait();
    idle();
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 9'b110101010 || model_out() !== outs()) begin
        errors++;
        $display("FAIL mem_wait_stall[%0d]: got %b expected %b", i, outs(), 9'b110101010);
      end
      tick();
    end
    bus.mem_ready = 1;
    @(negedge clk);
    checks++;
    if (outs() !== 9'b0) begin
      errors++;
      $display("FAIL mem_wait_release: got %b expected %b", outs(), 9'b0);
    end
    tick();
    bus.mem_req = 0; bus.mem_ready = 0;
    @(negedge clk);
    checks++;
    if (outs() !== 9'b0) begin
      errors++;
      $display("FAIL mem_wait_back_to_run: got %b expected %b", outs(), 9'b0);
    end
    tick();
    idle();
  endtask
  task automatic test_redirect_vs_lu();
    idle();
    bus.ex_redirect = 1; bus.ex_memread = 1; bus.ex_wraddr = 5; bus.id_rt = 5; bus.id_uses_rt = 1;
    @(negedge clk);
    checks++;
    if (outs() !== 9'b001010000) begin
      errors++;
      $display("FAIL redirect_beats_lu: got %b expected %b", outs(), 9'b001010000);
    end
    tick();
    idle();
  endtask
  task automatic test_redirect_during_wait();
    idle();
    bus.ex_redirect = 1; bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 9'b110101010) begin
        errors++;
        $display("FAIL redirect_wait_no_flush[%0d]: got %b expected %b", i, outs(), 9'b110101010);
      end
      tick();
    end
    bus.mem_ready = 1;
    @(negedge clk);
    checks++;
    if (outs() !== 9'b001010000) begin
      errors++;
      $display("FAIL redirect_wait_release: got %b expected %b", outs(), 9'b001010000);
    end
    tick();
    idle();
  endtask
  task automatic test_timeout();
    int n;
    n = 0;
    idle();
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_timeout === 1'b1) break;
      checks++;
      if (outs() !== model_out()) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got %b expected %b", i, outs(), model_out());
      end
      if (bus.pc_stall === 1'b1) n++;
      tick();
    end
    checks++;
    if (n !== TO + 1) begin
      errors++;
      $display("FAIL timeout_stall_cycles: got %0d expected %0d", n, TO + 1);
    end
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_req = 1'($urandom_range(0, 1));
      bus.ex_redirect = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (outs() !== 9'b110101011) begin
        errors++;
        $display("FAIL halt_sticky[%0d]: got %b expected %b", i, outs(), 9'b110101011);
      end
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    idle();
    @(negedge clk);
    checks++;
    if (outs() !== 9'b0) begin
      errors++;
      $display("FAIL halt_reset_recover: got %b expected %b", outs(), 9'b0);
    end
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.ex_wraddr = 5'($urandom_range(0, 3));
      bus.id_uses_rs = 1'($urandom_range(0, 1));
      bus.id_uses_rt = 1'($urandom_range(0, 1));
      bus.ex_memread = 1'($urandom_range(0, 1));
      bus.ex_redirect = ($urandom_range(0, 4) == 0);
      bus.mem_req = 1'($urandom_range(0, 1));
      bus.mem_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      checks++;
      if (outs() !== model_out()) begin
        errors++;
        $display("FAIL random[%0d]: got %b expected %b", i, outs(), model_out());
      end
`ifdef PIPE_HAZARD_PERF_EN
      checks++;
      if (perf_stall_cycles !== CW'(m_pst) || perf_flush_events !== CW'(m_pfl)) begin
        errors++;
        $display("FAIL perf[%0d]: got %0d/%0d expected %0d/%0d", i, perf_stall_cycles, perf_flush_events,
                 m_pst, m_pfl);
      end
`endif
      tick();
    end
    rst = 0;
    idle();
  endtask
  initial begin
    idle();
    #1;
    test_reset();
    test_load_use();
    test_load_zero();
    test_mem_wait();
    test_redirect_vs_lu();
    test_redirect_during_wait();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the stall/flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazard sources: data-memory wait states, taken branch/jump redirect from EX, and load-use dependencies.
- Times out a hung data-memory access and freezes the pipeline.

Parameters:
- MEM_TIMEOUT, 255: max consecutive data-memory wait cycles before the HALT state; legal range 1..65535.
- CNT_W, 16: width of the wait counter and the performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  instruction in EX is a load
- ex_wraddr  in  5  destination register of the instruction in EX
- ex_redirect  in  1  EX resolved a taken branch/jump
- mem_req  in  1  MEM stage holds a load or store
- mem_ready  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  ID/EX loads bubble (all controls 0)
- ex_mem_stall  out  1  hold EX/MEM
- ex_mem_flush  out  1  EX/MEM loads bubble
- mem_wb_flush  out  1  MEM/WB loads bubble
- mem_timeout  out  1  sticky hung-access flag

Behaviour:
- Clocking and reset:
  - Single clock; synchronous, active-high reset.
  - State, counters and mem_timeout update only on posedge clk.
  - All stall/flush outputs are combinational from state and inputs.
- While rst=1:
  - All *_flush=1, all *_stall=0, mem_timeout=0.
  - Next state RUN; wait_cnt=0.
  - Reset asserted in any state, including HALT, returns to RUN on the next edge.
- States: RUN, MEM_WAIT, HALT.
- Hazard terms:
  - memhold = mem_req & ~mem_ready.
  - lu = ex_memread & (ex_wraddr != 0) & ((id_uses_rs & id_rs == ex_wraddr) | (id_uses_rt & id_rt == ex_wraddr)).
- RUN, evaluated in priority order:
  1. memhold: pc/if_id/id_ex/ex_mem stalls=1, mem_wb_flush=1; next state MEM_WAIT; wait_cnt<=1.
  2. ex_redirect: if_id_flush=1 and id_ex_flush=1 (two wrong-path instructions killed); no stalls.
  3. lu: pc_stall=1, if_id_stall=1, id_ex_flush=1 (exactly one bubble).
  4. Otherwise all outputs 0.
  - Redirect beats load-use because the dependent instruction is on the wrong path.
- MEM_WAIT:
  - If mem_ready: outputs as in RUN without the memhold term (redirect/lu still evaluated); next RUN; wait_cnt<=0.
  - Else if wait_cnt == MEM_TIMEOUT: the memhold stall pattern stays in force; next HALT; mem_timeout<=1.
  - Else: memhold stall pattern; wait_cnt<=wait_cnt+1.
  - A redirect held in the frozen EX stage is acted on in the release cycle, never during the wait.
- HALT:
  - All four stalls=1, mem_wb_flush=1, mem_timeout=1; stays until reset.
- Latency:
  - Release is same-cycle with mem_ready; the pipeline advances on that edge.
  - A MEM_TIMEOUT=N access that never completes enters HALT after N+1 stalled cycles.
- Invariants:
  - Stall and flush are never both 1 on the same register.
  - ex_mem_flush=1 only during reset.
  - wait_cnt saturates at MEM_TIMEOUT, never wraps.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, adds outputs perf_stall_cycles[CNT_W-1:0] and perf_flush_events[CNT_W-1:0]:
  - perf_stall_cycles increments each cycle pc_stall=1 outside reset.
  - perf_flush_events increments each cycle if_id_flush or id_ex_flush is 1 outside reset.
  - Both saturate at all-ones and clear on rst.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - State enum (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2).
  - NOP constant 32'h0000_0020.
  - REG_ZERO=5'd0.
- Natural sub-module: hazard_detect_lu, a purely combinational lu term comparator reused by the forwarding unit; FSM and counters stay in the top.

Test Plan:
- Load-use: ex_memread=1, ex_wraddr=8, id_rs=8, id_uses_rs=1 -> for one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle (ex_memread=0) all 0.
- Load to $0: ex_wraddr=0, id_rs=0 -> no stall, no flush.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> stalls and mem_wb_flush high for exactly 3 cycles; state RUN after; mem_timeout=0.
- Redirect vs load-use: ex_redirect=1 and lu=1 in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Redirect during wait: ex_redirect=1 held through a 2-cycle wait -> no flush during wait; if_id_flush/id_ex_flush=1 in the mem_ready cycle.
- Timeout with MEM_TIMEOUT=4: mem_ready stuck 0 -> HALT after 5 stalled cycles, mem_timeout=1 sticky; rst=1 for 1 cycle -> RUN, mem_timeout=0.
